// File: rtl/ram32_fifo_arb_pkg.sv
// Shared constants and grant encoding for the ram32_fifo_arb FIFO controller.
package ram32_fifo_arb_pkg;

  localparam int unsigned FIFO_DW    = 12;
  localparam int unsigned FIFO_AW    = 5;
  localparam int unsigned FIFO_DEPTH = 32;

  typedef enum logic {
    GNT_P0 = 1'b0,
    GNT_P1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/ram32_fifo_arb_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant flop resets to P1 so P0 wins the first tie.
module rr_arb2
  import ram32_fifo_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic block,
  output logic gnt0_c,
  output logic gnt1_c
);

  gnt_e last;

  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!block) begin
      if (req0 && (!req1 || last == GNT_P1)) gnt0_c = 1'b1;
      else if (req1)                         gnt1_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= GNT_P1;
    else if (gnt0_c) last <= GNT_P0;
    else if (gnt1_c) last <= GNT_P1;
  end

endmodule

// File: rtl/ram32_fifo_arb.sv
// Shared FWFT FIFO over an external 32xDW distributed RAM, two arbitrated producers, one consumer.
// Optional high-water mark (HWM/HWM_CLR) enabled by defining RAM32_FIFO_HWM_EN.
module ram32_fifo_arb
  import ram32_fifo_arb_pkg::*;
#(
  parameter int unsigned DW = FIFO_DW,
  parameter int unsigned AW = FIFO_AW
) (
  input  logic          CLK,
  input  logic          RSTN,
`ifdef RAM32_FIFO_HWM_EN
  input  logic          HWM_CLR,
  output logic [AW:0]   HWM,
`endif
  input  logic          REQ0,
  input  logic [DW-1:0] DIN0,
  output logic          RDY0,
  input  logic          REQ1,
  input  logic [DW-1:0] DIN1,
  output logic          RDY1,
  output logic [DW-1:0] DOUT,
  output logic          DVALID,
  input  logic          DREADY,
  output logic [AW-1:0] RAM_WADDR,
  output logic [AW-1:0] RAM_RADDR,
  output logic [DW-1:0] RAM_DI,
  output logic          RAM_WE,
  input  logic [DW-1:0] RAM_DO,
  output logic [AW:0]   COUNT,
  output logic          FULL,
  output logic          EMPTY
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          we;
  logic          load;

  rr_arb2 u_arb (
    .clk    (CLK),
    .rst_n  (RSTN),
    .req0   (REQ0),
    .req1   (REQ1),
    .block  (FULL),
    .gnt0_c (RDY0),
    .gnt1_c (RDY1)
  );

  assign FULL  = (count == (AW+1)'(DEPTH));
  assign EMPTY = (count == (AW+1)'(0));
  assign we    = RDY0 | RDY1;
  assign load  = !EMPTY && (!dvalid || DREADY);

  assign RAM_WE    = we;
  assign RAM_DI    = RDY1 ? DIN1 : DIN0;
  assign RAM_WADDR = wptr;
  assign RAM_RADDR = rptr;
  assign COUNT     = count;
  assign DOUT      = dout;
  assign DVALID    = dvalid;

  always_comb begin
    count_nxt = count;
    if (we && !load)      count_nxt = count + (AW+1)'(1);
    else if (!we && load) count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (we)   wptr <= wptr + AW'(1);
      if (load) rptr <= rptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Output register: refill whenever it is empty or being consumed; hold DOUT when going invalid.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      dout   <= '0;
      dvalid <= 1'b0;
    end else if (load) begin
      dout   <= RAM_DO;
      dvalid <= 1'b1;
    end else if (dvalid && DREADY) begin
      dvalid <= 1'b0;
    end
  end

`ifdef RAM32_FIFO_HWM_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)               HWM <= '0;
    else if (HWM_CLR)        HWM <= count;
    else if (count_nxt > HWM) HWM <= count_nxt;
  end
`endif

endmodule

// File: tb/tb_ram32_fifo_arb.sv
// Scoreboard bench for ram32_fifo_arb with a behavioural 32x12 async-read RAM.
module tb_ram32_fifo_arb;
  import ram32_fifo_arb_pkg::*;

  localparam int unsigned DW = FIFO_DW;
  localparam int unsigned AW = FIFO_AW;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          REQ0 = 1'b0, REQ1 = 1'b0, DREADY = 1'b0;
  logic [DW-1:0] DIN0 = '0, DIN1 = '0;
  logic          RDY0, RDY1, DVALID, RAM_WE, FULL, EMPTY;
  logic [DW-1:0] DOUT, RAM_DI, RAM_DO;
  logic [AW-1:0] RAM_WADDR, RAM_RADDR;
  logic [AW:0]   COUNT;
`ifdef RAM32_FIFO_HWM_EN
  logic          HWM_CLR = 1'b0;
  logic [AW:0]   HWM;
`endif

  logic [DW-1:0] mem [32];
  logic [DW-1:0] exp_q [$];
  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (RAM_WE) mem[RAM_WADDR] <= RAM_DI;
  assign RAM_DO = mem[RAM_RADDR];

  ram32_fifo_arb dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
`ifdef RAM32_FIFO_HWM_EN
    .HWM_CLR   (HWM_CLR),
    .HWM       (HWM),
`endif
    .REQ0      (REQ0),
    .DIN0      (DIN0),
    .RDY0      (RDY0),
    .REQ1      (REQ1),
    .DIN1      (DIN1),
    .RDY1      (RDY1),
    .DOUT      (DOUT),
    .DVALID    (DVALID),
    .DREADY    (DREADY),
    .RAM_WADDR (RAM_WADDR),
    .RAM_RADDR (RAM_RADDR),
    .RAM_DI    (RAM_DI),
    .RAM_WE    (RAM_WE),
    .RAM_DO    (RAM_DO),
    .COUNT     (COUNT),
    .FULL      (FULL),
    .EMPTY     (EMPTY)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every consumed word must match the head of the expected queue.
  always @(negedge CLK) begin
    logic [DW-1:0] e;
    if (RSTN && DVALID && DREADY) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got 0x%0h expected none at %0t", DOUT, $time);
      end else begin
        e = exp_q.pop_front();
        chk("drain_order", 32'(DOUT), 32'(e));
      end
    end
  end

  task automatic apply_reset();
    RSTN = 1'b0;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    DREADY = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    bit done = 1'b0;
    DREADY = 1'b1;
    for (int i = 0; i < max_cyc && !done; i++) begin
      cyc();
      if (!DVALID && EMPTY) done = 1'b1;
    end
    chk("drain_done", 32'(done), 32'd1);
    DREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    RSTN = 1'b0;
    #2;
    chk("rst_dvalid", 32'(DVALID), 32'd0);
    chk("rst_dout",   32'(DOUT),   32'd0);
    chk("rst_count",  32'(COUNT),  32'd0);
    chk("rst_full",   32'(FULL),   32'd0);
    chk("rst_empty",  32'(EMPTY),  32'd1);
    chk("rst_waddr",  32'(RAM_WADDR), 32'd0);
    apply_reset();

    // Single word latency
    cyc();
    REQ0 = 1'b1; DIN0 = 12'h123; DREADY = 1'b0;
    #1;
    chk("t1_we",    32'(RAM_WE),    32'd1);
    chk("t1_waddr", 32'(RAM_WADDR), 32'd0);
    chk("t1_di",    32'(RAM_DI),    32'h123);
    chk("t1_rdy0",  32'(RDY0),      32'd1);
    chk("t1_rdy1",  32'(RDY1),      32'd0);
    exp_q.push_back(12'h123);
    cyc();
    REQ0 = 1'b0;
    chk("t1_dvalid_k",  32'(DVALID), 32'd0);
    chk("t1_count_k",   32'(COUNT),  32'd1);
    cyc();
    chk("t1_dvalid_k1", 32'(DVALID), 32'd1);
    chk("t1_dout_k1",   32'(DOUT),   32'h123);
    chk("t1_count_k1",  32'(COUNT),  32'd0);
    chk("t1_empty_k1",  32'(EMPTY),  32'd1);
    drain(10);

    // Round-robin alternation with both producers requesting
    apply_reset();
    exp_q.push_back(12'hA00); exp_q.push_back(12'hB00);
    exp_q.push_back(12'hA01); exp_q.push_back(12'hB01);
    exp_q.push_back(12'hA02); exp_q.push_back(12'hB02);
    for (int i = 0; i < 6; i++) begin
      cyc();
      REQ0 = 1'b1; REQ1 = 1'b1; DREADY = 1'b1;
      DIN0 = 12'hA00 + 12'((i + 1) / 2);
      DIN1 = 12'hB00 + 12'(i / 2);
      #1;
      chk("rr_rdy0", 32'(RDY0), 32'((i % 2) == 0));
      chk("rr_rdy1", 32'(RDY1), 32'((i % 2) == 1));
    end
    cyc();
    REQ0 = 1'b0; REQ1 = 1'b0;
    drain(20);

    // P1 alone fills all 33 slots
    for (int i = 0; i < 33; i++) exp_q.push_back(12'h300 + 12'(i));
    for (int i = 0; i < 40; i++) begin
      cyc();
      REQ1 = 1'b1; DREADY = 1'b0;
      DIN1 = 12'h300 + 12'((i < 33) ? i : 33);
      #1;
      chk("fill_rdy1", 32'(RDY1), 32'(i <= 32));
    end
    cyc();
    chk("fill_full",   32'(FULL),   32'd1);
    chk("fill_count",  32'(COUNT),  32'd32);
    chk("fill_dvalid", 32'(DVALID), 32'd1);
    DREADY = 1'b1;
    #1;
    chk("pulse_rdy1_blocked", 32'(RDY1), 32'd0);
    cyc();
    DREADY = 1'b0;
    #1;
    chk("pulse_rdy1_reopen", 32'(RDY1), 32'd1);
    exp_q.push_back(12'h321);
    cyc();
    REQ1 = 1'b0;
    drain(100);

    // Streaming 100 words with pointer wrap
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      cyc();
      REQ0 = 1'b1; DREADY = 1'b1;
      DIN0 = 12'h400 + 12'(i);
      #1;
      chk("stream_rdy0",  32'(RDY0),      32'd1);
      chk("stream_waddr", 32'(RAM_WADDR), 32'(i % 32));
      chk("stream_cnt",   32'(COUNT <= (AW+1)'(1)), 32'd1);
      exp_q.push_back(12'h400 + 12'(i));
    end
    cyc();
    REQ0 = 1'b0;
    drain(10);

    // Mid-cycle reset discards stored words
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      cyc();
      REQ0 = 1'b1; DREADY = 1'b0;
      DIN0 = 12'h600 + 12'(i);
    end
    cyc();
    REQ0 = 1'b0;
    #2;
    RSTN = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_dvalid", 32'(DVALID), 32'd0);
    chk("mrst_count",  32'(COUNT),  32'd0);
    chk("mrst_empty",  32'(EMPTY),  32'd1);
    @(negedge CLK);
    RSTN = 1'b1;
    cyc();
    REQ0 = 1'b1; DIN0 = 12'h5A5;
    #1;
    chk("mrst_rdy0", 32'(RDY0), 32'd1);
    exp_q.push_back(12'h5A5);
    cyc();
    REQ0 = 1'b0;
    drain(10);

`ifdef RAM32_FIFO_HWM_EN
    // High-water mark
    apply_reset();
    for (int i = 0; i < 21; i++) begin
      cyc();
      REQ0 = 1'b1; DREADY = 1'b0;
      DIN0 = 12'h700 + 12'(i);
      exp_q.push_back(12'h700 + 12'(i));
    end
    cyc();
    REQ0 = 1'b0;
    chk("hwm_count20", 32'(COUNT), 32'd20);
    chk("hwm_peak",    32'(HWM),   32'd20);
    DREADY = 1'b1;
    repeat (17) cyc();
    DREADY = 1'b0;
    chk("hwm_count3", 32'(COUNT), 32'd3);
    chk("hwm_hold",   32'(HWM),   32'd20);
    HWM_CLR = 1'b1;
    cyc();
    HWM_CLR = 1'b0;
    chk("hwm_clr", 32'(HWM), 32'd3);
    drain(20);
`endif

    cyc();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
